// File: rtl/apb_reg_master_if.sv
// Request/response and APB signal bundle for apb_reg_master.
// Both req and rsp channels transfer on a rising clock edge where valid && ready; a valid holder keeps its payload stable until that edge.
interface apb_reg_master_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_status;
  logic                  busy;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [31:0]           PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PREADY, PSLVERR, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_status, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PREADY, PSLVERR, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_reg_master.sv
// Single-outstanding APB3 master: one request in, one APB transfer out, one response back,
// with alignment checking and a PREADY timeout bounding the access phase.
module apb_reg_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   RegClk,
  input  logic                   RegReset,
  apb_reg_master_if.master       bus,
  output logic [1:0]             o_dbg_state
);

  localparam int  CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  TO_EN  = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_SLVERR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_MISALIGN = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_req_ready;
  logic                  r_busy;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic [1:0]            r_rsp_status;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]           r_pwdata;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_timeout_hit;

  assign w_cnt_inc     = r_cnt + CW'(1);
  assign w_timeout_hit = TO_EN && (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  // Async reset clears PSEL/PENABLE/rsp_valid immediately, discarding any transfer in flight.
  always_ff @(posedge RegClk or posedge RegReset) begin
    if (RegReset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= ST_OK;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_pwrite    <= bus.req_write;
            r_paddr     <= bus.req_addr;
            r_pwdata    <= bus.req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.req_addr[1:0] != 2'b00) begin
              r_state      <= S_RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_MISALIGN;
              r_rsp_rdata  <= '0;
            end else begin
              r_state <= S_SETUP;
              r_psel  <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          // A completing PREADY takes priority over a timeout reached in the same cycle.
          if (bus.PREADY) begin
            r_state      <= S_RESP;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= r_pwrite ? 32'd0 : bus.PRDATA;
            r_rsp_status <= bus.PSLVERR ? ST_SLVERR : ST_OK;
          end else if (w_timeout_hit) begin
            r_state      <= S_RESP;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= '0;
            r_rsp_status <= ST_TIMEOUT;
            r_cnt        <= w_cnt_inc;
          end else if (TO_EN) begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.busy       = r_busy;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_status = r_rsp_status;
  assign bus.PSEL       = r_psel;
  assign bus.PENABLE    = r_penable;
  assign bus.PWRITE     = r_pwrite;
  assign bus.PADDR      = r_paddr;
  assign bus.PWDATA     = r_pwdata;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/apb_reg_master.md
# apb_reg_master

Single-outstanding APB3 master that converts a simple valid/ready request/response interface into APB transfers toward the `*_regs_top` register blocks. It sits directly upstream of a register block, driving its PSEL/PENABLE/PWRITE/PADDR/PWDATA and sampling PREADY/PRDATA/PSLVERR. It enforces word alignment and the one-cycle access phase that read-side FIFO pops (rinc) depend on, and bounds every transfer with a PREADY timeout.

## Interface
- ADDR_WIDTH, 8, APB address width; must match the slave.
- TIMEOUT_CYCLES, 16, consecutive PREADY-low access cycles before abort; 0 disables the timeout.
- RegClk  in  1  clock; all logic on rising edge.
- RegReset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  read data; 0 for writes and errors other than SLVERR.
- rsp_status  out  2  00 OK, 01 SLVERR, 10 TIMEOUT, 11 MISALIGNED.
- busy  out  1  high in any state other than IDLE.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PREADY, PSLVERR  in  1 each  APB slave response.
- PRDATA  in  32  APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered.
- IDLE: req_ready=1. On req_valid, capture write/addr/wdata.
  - req_addr[1:0]!=0: go to RESP, status 11, rdata 0, no APB activity.
  - Otherwise go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Each cycle:
  - PREADY=1: go to RESP.
    - Read: rdata=PRDATA.
    - Write: rdata=0.
    - status=01 if PSLVERR else 00. On SLVERR reads, PRDATA is still captured.
  - PREADY=0: timeout counter increments. When it reaches TIMEOUT_CYCLES, go to RESP with status 10, rdata 0.
  - PREADY=1 in the same cycle the count is reached: PREADY wins.
- Counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP. It never wraps; the abort happens first.
- RESP: rsp_valid=1, with rdata/status stable, until rsp_ready; then IDLE. req_ready=0 throughout, so only one transfer is ever outstanding.
- PADDR, PWRITE and PWDATA:
  - Load on request accept.
  - Stay stable through SETUP and ACCESS.
  - Hold their last value in IDLE and RESP.
- PSEL and PENABLE are 0 outside SETUP and ACCESS.
- Exactly one cycle has PSEL&PENABLE&PREADY per transfer, so a read of a read-FIFO register pops exactly one entry.

## Timing
- Reset values: PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0; rsp_valid = 0; rsp_rdata = 0; rsp_status = 00; busy = 0; req_ready = 1; state IDLE; counter 0.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously. Any pending response is discarded. No rsp_valid pulse follows reset.
- Accept at edge 0 with PREADY=1 (zero-wait slave):
  - PSEL high at cycles 1–2.
  - PENABLE high at cycle 2.
  - rsp_valid high from cycle 3.
  - Minimum transfer-to-transfer spacing is 4 cycles with rsp_ready held high.
- Misaligned request: rsp_valid is asserted the cycle after accept.
- Timeout at TIMEOUT_CYCLES=N: PENABLE stays high for N cycles, then drops. rsp_valid follows on the next cycle.
- rsp_ready held low: the FSM stays in RESP indefinitely and no new request is accepted.

## Test plan
- Write addr 0x00, data 0x0000001F, PREADY=1 -> PSEL on cycles 1–2, PENABLE on cycle 2 with PWRITE=1 and PWDATA=0x1F; rsp_valid on cycle 3 with status 00, rdata 0; slave REG1 reads back 0x1F.
- Read addr 0x0C with read FIFO holding 0xA5, 0x5A -> exactly one PENABLE cycle; rdata 0x000000A5, status 00; FIFO then holds only 0x5A.
- PREADY forced 0, TIMEOUT_CYCLES=16 -> PENABLE high for exactly 16 cycles; rsp status 10, rdata 0. A variant asserting PREADY on the 16th cycle returns status 00.
- Read addr 0x40 (unmapped, PSLVERR=1) -> status 01, rdata = PRDATA (0). Misaligned addr 0x06 -> PSEL never asserts; status 11 one cycle after accept.
- rsp_ready held low for 10 cycles with req_valid high -> req_ready=0 and PSEL=0 throughout; the second request starts the cycle after rsp_ready rises.
- RegReset asserted during ACCESS -> PSEL, PENABLE and rsp_valid are 0 immediately; after release, req_ready=1 and a new write completes normally.
